// File: rtl/gpio_bridge_pkg.sv
// gpio_bridge_pkg: opcodes, error byte and FSM states shared by the GPIO bridge.
package gpio_bridge_pkg;

   localparam logic [7:0] OP_WR_OUT   = 8'h10;
   localparam logic [7:0] OP_WR_OE    = 8'h20;
   localparam logic [7:0] OP_RD_IN    = 8'h30;
   localparam logic [7:0] OP_RD_EDGE  = 8'h40;
   localparam logic [7:0] OP_WR_SLEEP = 8'h50;
   localparam logic [7:0] ERR_BYTE    = 8'hEE;

   typedef enum logic [1:0] {ST_IDLE, ST_ARG, ST_RESP} state_t;

   function automatic logic is_arg_op(input logic [7:0] op);
      return op == OP_WR_OUT || op == OP_WR_OE || op == OP_WR_SLEEP;
   endfunction

endpackage

// File: rtl/gpio_bridge_if.sv
// gpio_bridge_if: USB CDC byte channel (host-to-device command stream, device-to-host responses).
interface gpio_bridge_if;

   logic [7:0] out_data_i;
   logic       out_valid_i;
   logic       out_ready_o;
   logic [7:0] in_data_o;
   logic       in_valid_o;
   logic       in_ready_i;

   modport master (
      output out_data_i, out_valid_i, in_ready_i,
      input  out_ready_o, in_data_o, in_valid_o
   );

   modport slave (
      input  out_data_i, out_valid_i, in_ready_i,
      output out_ready_o, in_data_o, in_valid_o
   );

endinterface

// File: rtl/gpio_bridge_sync.sv
// gpio_bridge_sync: per-pin synchroniser, edge pulse and, with GPIO_BRIDGE_DEBOUNCE_EN, a debouncer.
module gpio_bridge_sync #(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic clk_i,
   input  logic rstn_i,
   input  logic i_pad,
   input  logic i_arm,
   output logic o_val,
   output logic o_edge
);

   if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1) begin : g_bad_cfg
      $error("gpio_bridge_sync: SYNC_STAGES must be >= 2 and DEBOUNCE_CYCLES >= 1");
   end

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_prev;
   logic                   w_sync;
   logic                   w_val;

   assign w_sync = r_sync[SYNC_STAGES-1];

   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         r_sync <= '0;
         r_prev <= 1'b0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], i_pad};
         r_prev <= w_val;
      end
   end

`ifdef GPIO_BRIDGE_DEBOUNCE_EN
   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

   logic [CW-1:0] r_cnt;
   logic          r_acc;

   // Until armed the accepted value tracks the synchroniser, so fill is never debounced into an edge.
   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         r_cnt <= '0;
         r_acc <= 1'b0;
      end else if (!i_arm) begin
         r_cnt <= '0;
         r_acc <= w_sync;
      end else if (w_sync == r_acc) begin
         r_cnt <= '0;
      end else if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
         r_cnt <= '0;
         r_acc <= w_sync;
      end else begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign w_val = i_arm ? r_acc : w_sync;
`else
   assign w_val = w_sync;
`endif

   assign o_val  = w_val;
   assign o_edge = i_arm & (w_val ^ r_prev);

endmodule

// File: rtl/gpio_bridge.sv
// gpio_bridge: byte-command GPIO controller on a USB CDC channel.
// Define GPIO_BRIDGE_DEBOUNCE_EN to debounce inputs before RD_IN and edge detection.
module gpio_bridge
   import gpio_bridge_pkg::*;
#(
   parameter int GPIO_NUM        = 8,
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic                clk_i,
   input  logic                rstn_i,
   gpio_bridge_if.slave        cdc,
   input  logic [GPIO_NUM-1:0] gpio_i,
   output logic [GPIO_NUM-1:0] gpio_o,
   output logic [GPIO_NUM-1:0] gpio_oe_o,
   output logic                sleep_o
);

   if (GPIO_NUM < 1 || GPIO_NUM > 8) begin : g_bad_cfg
      $error("gpio_bridge: GPIO_NUM must be 1..8");
   end

   localparam int ARM_CNT = SYNC_STAGES + 1;
   localparam int AW      = $clog2(ARM_CNT + 1);

   state_t                r_state, w_next;
   logic                  r_run;
   logic [AW-1:0]         r_arm_cnt;
   logic [7:0]            r_op;
   logic [7:0]            r_in_data;
   logic [GPIO_NUM-1:0]   r_out, r_oe, r_flags;
   logic                  r_sleep;
   logic [GPIO_NUM-1:0]   w_val, w_edge;
   logic                  w_arm, w_ofire, w_ifire, w_clear;
   logic [7:0]            w_resp;

   for (genvar i = 0; i < GPIO_NUM; i++) begin : g_pin
      gpio_bridge_sync #(
         .SYNC_STAGES    (SYNC_STAGES),
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_sync (
         .clk_i (clk_i),
         .rstn_i(rstn_i),
         .i_pad (gpio_i[i]),
         .i_arm (w_arm),
         .o_val (w_val[i]),
         .o_edge(w_edge[i])
      );
   end

   assign w_arm   = r_arm_cnt == AW'(ARM_CNT);
   assign w_ofire = cdc.out_valid_i & cdc.out_ready_o;
   assign w_ifire = cdc.in_valid_o & cdc.in_ready_i;
   assign w_clear = r_state == ST_IDLE && w_ofire && cdc.out_data_i == OP_RD_EDGE;
   assign w_resp  = cdc.out_data_i == OP_RD_IN   ? 8'(w_val)   :
                    cdc.out_data_i == OP_RD_EDGE ? 8'(r_flags) : ERR_BYTE;

   always_ff @(posedge clk_i) begin
      if (!rstn_i) r_state <= ST_IDLE;
      else         r_state <= w_next;
   end

   always_comb begin
      w_next = r_state == ST_IDLE ? (w_ofire ? (is_arg_op(cdc.out_data_i) ? ST_ARG : ST_RESP) : ST_IDLE) :
               r_state == ST_ARG  ? (w_ofire ? ST_IDLE : ST_ARG) :
                                    (w_ifire ? ST_IDLE : ST_RESP);
   end

   always_comb begin
      cdc.out_ready_o = r_run && r_state != ST_RESP;
      cdc.in_valid_o  = r_state == ST_RESP;
      cdc.in_data_o   = r_in_data;
   end

   // Flags: a same-cycle edge survives the RD_EDGE clear.
   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         r_run     <= 1'b0;
         r_arm_cnt <= '0;
         r_op      <= '0;
         r_in_data <= '0;
         r_out     <= '0;
         r_oe      <= '0;
         r_sleep   <= 1'b0;
         r_flags   <= '0;
      end else begin
         r_run     <= 1'b1;
         r_arm_cnt <= w_arm ? r_arm_cnt : r_arm_cnt + 1'b1;
         r_flags   <= (w_clear ? '0 : r_flags) | w_edge;
         if (w_ofire && r_state == ST_IDLE) begin
            r_op <= cdc.out_data_i;
            if (!is_arg_op(cdc.out_data_i)) r_in_data <= w_resp;
         end
         if (w_ofire && r_state == ST_ARG) begin
            if (r_op == OP_WR_OUT)   r_out   <= cdc.out_data_i[GPIO_NUM-1:0];
            if (r_op == OP_WR_OE)    r_oe    <= cdc.out_data_i[GPIO_NUM-1:0];
            if (r_op == OP_WR_SLEEP) r_sleep <= cdc.out_data_i[0];
         end
      end
   end

   assign gpio_o    = r_out;
   assign gpio_oe_o = r_oe;
   assign sleep_o   = r_sleep;

endmodule

// File: tb/tb_gpio_bridge.sv
// tb_gpio_bridge: directed bench with a cycle-level reference model of gpio_bridge.
// Define GPIO_BRIDGE_DEBOUNCE_EN to also exercise the debounce build.
module tb_gpio_bridge;

   localparam int S = 2;
   localparam int D = 16;
`ifdef GPIO_BRIDGE_DEBOUNCE_EN
   localparam int LAG = S + D;
`else
   localparam int LAG = S;
`endif
   localparam int SETTLE = LAG + 4;

   logic       clk = 1'b0;
   logic       rstn;
   logic [7:0] gpio_in, gpio_out, gpio_oe;
   logic       sleep;
   logic [1:0] g2_i, g2_o, g2_oe;
   logic       sleep2;
   int         n_checks = 0;
   int         n_errors = 0;

   gpio_bridge_if cdc();
   gpio_bridge_if c2();

   gpio_bridge #(.GPIO_NUM(8), .SYNC_STAGES(S), .DEBOUNCE_CYCLES(D)) dut (
      .clk_i(clk), .rstn_i(rstn), .cdc(cdc), .gpio_i(gpio_in),
      .gpio_o(gpio_out), .gpio_oe_o(gpio_oe), .sleep_o(sleep)
   );

   gpio_bridge #(.GPIO_NUM(2), .SYNC_STAGES(S), .DEBOUNCE_CYCLES(D)) dut2 (
      .clk_i(clk), .rstn_i(rstn), .cdc(c2), .gpio_i(g2_i),
      .gpio_o(g2_o), .gpio_oe_o(g2_oe), .sleep_o(sleep2)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   // Reference model: synchronised value is the pad sampled S clocks earlier.
   logic [7:0] hist[$];
   int         m_k;
   bit         m_init = 0;
   bit         m_run;
   int         m_mode;
   logic [7:0] m_op, m_out, m_oe, m_flags, m_in_data, m_val_prev;
   logic       m_sleep;
`ifdef GPIO_BRIDGE_DEBOUNCE_EN
   logic [7:0] m_acc;
   int         m_len[8];
`endif

   function automatic logic [7:0] sync_at(input int k);
      return (k >= S) ? hist[k-S] : 8'h00;
   endfunction

   function automatic logic [7:0] val_now();
`ifdef GPIO_BRIDGE_DEBOUNCE_EN
      return (m_k < S + 1) ? sync_at(m_k) : m_acc;
`else
      return sync_at(m_k);
`endif
   endfunction

   always @(posedge clk) begin : model
      logic [7:0] v, e, d, s;
      bit ofire, ifire, clear;
      if (!rstn) begin
         hist.delete();
         m_k = 0; m_run = 0; m_mode = 0; m_op = 0; m_out = 0; m_oe = 0;
         m_flags = 0; m_in_data = 0; m_val_prev = 0; m_sleep = 0; m_init = 1;
`ifdef GPIO_BRIDGE_DEBOUNCE_EN
         m_acc = 0;
         foreach (m_len[b]) m_len[b] = 0;
`endif
      end else begin
         v = val_now();
         s = sync_at(m_k);
         e = (m_k >= S + 1) ? (v ^ m_val_prev) : 8'h00;
         d = cdc.out_data_i;
         ofire = cdc.out_valid_i && m_run && m_mode != 2;
         ifire = m_mode == 2 && cdc.in_ready_i;
         clear = 0;
         if (ofire && m_mode == 0) begin
            if (d == 8'h10 || d == 8'h20 || d == 8'h50) begin
               m_mode = 1;
               m_op = d;
            end else begin
               m_mode = 2;
               m_in_data = d == 8'h30 ? v : d == 8'h40 ? m_flags : 8'hEE;
               clear = d == 8'h40;
            end
         end else if (ofire && m_mode == 1) begin
            if (m_op == 8'h10) m_out = d;
            if (m_op == 8'h20) m_oe = d;
            if (m_op == 8'h50) m_sleep = d[0];
            m_mode = 0;
         end else if (ifire) begin
            m_mode = 0;
         end
         m_flags = (clear ? 8'h00 : m_flags) | e;
`ifdef GPIO_BRIDGE_DEBOUNCE_EN
         for (int b = 0; b < 8; b++) begin
            if (m_k < S + 1) begin
               m_acc[b] = s[b];
               m_len[b] = 0;
            end else if (s[b] != m_acc[b]) begin
               m_len[b]++;
               if (m_len[b] == D) begin
                  m_acc[b] = s[b];
                  m_len[b] = 0;
               end
            end else begin
               m_len[b] = 0;
            end
         end
`endif
         m_val_prev = v;
         hist.push_back(gpio_in);
         m_k++;
         m_run = 1;
      end
   end

   always @(negedge clk) begin
      if (m_init) begin
         chk("m_out_ready", 32'(cdc.out_ready_o), 32'(m_run && m_mode != 2));
         chk("m_in_valid",  32'(cdc.in_valid_o),  32'(m_mode == 2));
         chk("m_in_data",   32'(cdc.in_data_o),   32'(m_in_data));
         chk("m_gpio_o",    32'(gpio_out),        32'(m_out));
         chk("m_gpio_oe",   32'(gpio_oe),         32'(m_oe));
         chk("m_sleep",     32'(sleep),           32'(m_sleep));
      end
   end

   task automatic send(input logic [7:0] b);
      int n = 0;
      cdc.out_valid_i = 1'b1;
      cdc.out_data_i  = b;
      while (!cdc.out_ready_o && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!cdc.out_ready_o) begin
         n_checks++;
         n_errors++;
         $display("FAIL send_timeout: out_ready_o=0 for byte 0x%02h, required 1", b);
      end
      @(negedge clk);
      cdc.out_valid_i = 1'b0;
   endtask

   task automatic read_resp(output logic [7:0] d);
      int n = 0;
      while (!cdc.in_valid_o && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!cdc.in_valid_o) begin
         n_checks++;
         n_errors++;
         $display("FAIL resp_timeout: in_valid_o=0, required 1");
      end
      d = cdc.in_data_o;
      cdc.in_ready_i = 1'b1;
      @(negedge clk);
      cdc.in_ready_i = 1'b0;
   endtask

   task automatic op(input logic [7:0] b, input logic [7:0] exp, input string nm);
      logic [7:0] d;
      send(b);
      read_resp(d);
      chk(nm, 32'(d), 32'(exp));
   endtask

   initial begin
      #200000;
      n_errors++;
      $display("FAIL watchdog: bench did not reach its end, required completion");
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      rstn = 1'b0;
      gpio_in = 8'h00;
      g2_i = 2'b10;
      cdc.out_valid_i = 1'b0;
      cdc.out_data_i = 8'h00;
      cdc.in_ready_i = 1'b0;
      c2.out_valid_i = 1'b0;
      c2.out_data_i = 8'h00;
      c2.in_ready_i = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_gpio_o", 32'(gpio_out), 0);
      chk("rst_gpio_oe", 32'(gpio_oe), 0);
      chk("rst_sleep", 32'(sleep), 0);
      chk("rst_in_valid", 32'(cdc.in_valid_o), 0);
      chk("rst_in_data", 32'(cdc.in_data_o), 0);
      chk("rst_out_ready", 32'(cdc.out_ready_o), 0);
      rstn = 1'b1;
      @(negedge clk);
      chk("ready_after_release", 32'(cdc.out_ready_o), 1);

      send(8'h10); send(8'hA5);
      chk("wr_out", 32'(gpio_out), 32'hA5);
      send(8'h20); send(8'h0F);
      chk("wr_oe", 32'(gpio_oe), 32'h0F);
      chk("wr_oe_keeps_out", 32'(gpio_out), 32'hA5);

      gpio_in = 8'h3C;
      repeat (SETTLE) @(negedge clk);
      send(8'h30);
      for (int i = 0; i < 5; i++) begin
         chk("hold_valid", 32'(cdc.in_valid_o), 1);
         chk("hold_data", 32'(cdc.in_data_o), 32'h3C);
         chk("hold_not_ready", 32'(cdc.out_ready_o), 0);
         @(negedge clk);
      end
      cdc.in_ready_i = 1'b1;
      @(negedge clk);
      cdc.in_ready_i = 1'b0;
      chk("resp_done_valid", 32'(cdc.in_valid_o), 0);
      chk("resp_done_ready", 32'(cdc.out_ready_o), 1);

      op(8'h40, 8'h3C, "edge_initial");
      gpio_in = 8'h38;
      repeat (SETTLE) @(negedge clk);
      op(8'h40, 8'h04, "edge_bit2");
      op(8'h40, 8'h00, "edge_cleared");

      gpio_in = gpio_in ^ 8'h02;
      repeat (LAG) @(negedge clk);
      op(8'h40, 8'h00, "edge_same_cycle_snapshot");
      op(8'h40, 8'h02, "edge_same_cycle_kept");

      op(8'h77, 8'hEE, "bad_opcode");
      send(8'h50); send(8'h01);
      chk("wr_sleep", 32'(sleep), 1);

      c2.out_valid_i = 1'b1;
      c2.out_data_i = 8'h10;
      @(negedge clk);
      c2.out_data_i = 8'hFF;
      @(negedge clk);
      chk("n2_gpio_o", 32'(g2_o), 32'h3);
      chk("n2_gpio_oe", 32'(g2_oe), 0);
      c2.out_data_i = 8'h30;
      @(negedge clk);
      c2.out_valid_i = 1'b0;
      chk("n2_rd_valid", 32'(c2.in_valid_o), 1);
      chk("n2_rd_data", 32'(c2.in_data_o), 32'h02);
      chk("n2_sleep", 32'(sleep2), 0);

      gpio_in = 8'hFF;
      rstn = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst2_gpio_o", 32'(gpio_out), 0);
      chk("rst2_sleep", 32'(sleep), 0);
      rstn = 1'b1;
      repeat (SETTLE) @(negedge clk);
      op(8'h40, 8'h00, "no_fill_edge");
      op(8'h30, 8'hFF, "rd_in_ff");

      send(8'h10);
      rstn = 1'b0;
      @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);
      chk("abort_arg_gpio_o", 32'(gpio_out), 0);
      chk("abort_arg_ready", 32'(cdc.out_ready_o), 1);
      repeat (SETTLE) @(negedge clk);
      op(8'h30, 8'hFF, "abort_arg_next_is_opcode");
      chk("abort_arg_gpio_o_kept", 32'(gpio_out), 0);

      send(8'h30);
      rstn = 1'b0;
      @(negedge clk);
      rstn = 1'b1;
      chk("abort_resp_valid", 32'(cdc.in_valid_o), 0);
      chk("abort_resp_data", 32'(cdc.in_data_o), 0);
      repeat (SETTLE) @(negedge clk);

`ifdef GPIO_BRIDGE_DEBOUNCE_EN
      gpio_in = 8'h00;
      repeat (SETTLE) @(negedge clk);
      op(8'h40, 8'hFF, "db_clear");
      gpio_in = 8'h01;
      repeat (10) @(negedge clk);
      gpio_in = 8'h00;
      repeat (SETTLE) @(negedge clk);
      op(8'h30, 8'h00, "db_short_rd_in");
      op(8'h40, 8'h00, "db_short_no_edge");
      gpio_in = 8'h01;
      repeat (20 + S) @(negedge clk);
      op(8'h30, 8'h01, "db_long_rd_in");
      op(8'h40, 8'h01, "db_long_edge");
`endif

      repeat (3) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
